// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchroniser, debounce FSM, press/release/long-press
// event pulses and a wrapping press counter. All outputs come straight from flops.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int LONG_PRESS_CYCLES = 27000000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_pin,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       long_active,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            long_q, long_d;
    logic            lact_q, lact_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            raw;

    // Synchroniser resets to the released level so reset cannot look like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= btn_pin;
            sync2_q <= sync1_q;
        end
    end

    assign raw = sync2_q ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            lact_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            lact_q  <= lact_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        lact_d  = lact_q;
        cnt_d   = cnt_q;

        // Hold timer runs through release bounces; saturating at the threshold
        // guarantees a single long pulse per press.
        if ((state_q == HELD || state_q == RELEASE_CHK) && hcnt_q < H_LAST) begin
            hcnt_d = hcnt_q + HW'(1);
            if (hcnt_q + HW'(1) == H_LAST) begin
                long_d = 1'b1;
                lact_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (raw) begin
                    state_d = PRESS_CHK;
                    dcnt_d  = DW'(1);
                end
            end
            PRESS_CHK: begin
                if (!raw) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q >= D_LAST) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!raw) begin
                    state_d = RELEASE_CHK;
                    dcnt_d  = DW'(1);
                end
            end
            RELEASE_CHK: begin
                if (raw) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                end else if (dcnt_q >= D_LAST) begin
                    // Release wins over a long-press threshold crossed on the same edge.
                    state_d = IDLE;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                    long_d  = 1'b0;
                    lact_d  = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign long_active   = lact_q;
    assign press_count   = cnt_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed and random pin sequences compared every
// cycle against a run-length debounce model, plus explicit event-count checks.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_pin = 1'b1;
    logic       btn_level, press_pulse, release_pulse, long_pulse, long_active;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_s1, m_s2, m_level, m_lact, m_press, m_rel, m_long;
    int         m_run, m_age;
    logic [7:0] m_cnt;

    // Pulse tallies observed on the DUT, compared against required totals
    int n_press, n_rel, n_long;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_PRESS_CYCLES(L),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_pin(btn_pin),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .long_active(long_active),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1;
        m_level = 1'b0; m_lact = 1'b0;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        m_run = 0; m_age = 0; m_cnt = 8'd0;
    endtask

    // Level flips after D consecutive samples disagreeing with it; the press age
    // counts edges since acceptance and the long event fires when it reaches L-1.
    task automatic model_edge(input logic pin);
        logic pressed;
        pressed = ~m_s2;
        m_s2 = m_s1;
        m_s1 = pin;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        if (pressed != m_level) m_run = m_run + 1;
        else m_run = 0;
        if (m_run == D) begin
            m_run = 0;
            m_age = 0;
            if (pressed) begin
                m_level = 1'b1; m_press = 1'b1; m_cnt = m_cnt + 8'd1;
            end else begin
                m_level = 1'b0; m_rel = 1'b1; m_lact = 1'b0;
            end
        end else if (m_level && m_age < L - 1) begin
            m_age = m_age + 1;
            if (m_age == L - 1) begin
                m_long = 1'b1; m_lact = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("btn_level", int'(btn_level), int'(m_level));
        chk("press_pulse", int'(press_pulse), int'(m_press));
        chk("release_pulse", int'(release_pulse), int'(m_rel));
        chk("long_pulse", int'(long_pulse), int'(m_long));
        chk("long_active", int'(long_active), int'(m_lact));
        chk("press_count", int'(press_count), int'(m_cnt));
        n_press += int'(press_pulse);
        n_rel   += int'(release_pulse);
        n_long  += int'(long_pulse);
    endtask

    task automatic step(input logic pin);
        btn_pin = pin;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge(pin);
        #1;
        check_all();
    endtask

    initial begin
        logic       rpin;
        int         len;
        logic [7:0] c0;
        n_press = 0; n_rel = 0; n_long = 0;

        // Reset with the pin released, then idle released
        model_reset();
        #1;
        check_all();
        repeat (3) step(1'b1);
        reset_n = 1'b1;
        repeat (50) step(1'b1);
        chk("idle_no_press", n_press, 0);

        // Clean press: accepted on the sixth edge
        repeat (5) step(1'b0);
        chk("level_before_accept", int'(btn_level), 0);
        step(1'b0);
        chk("press_at_edge6", int'(press_pulse), 1);
        chk("count_first", int'(press_count), 1);
        step(1'b0);
        chk("press_one_cycle", int'(press_pulse), 0);

        // Long hold then clean release
        n_long = 0;
        repeat (38) step(1'b0);
        chk("long_once", n_long, 1);
        chk("long_active_held", int'(long_active), 1);
        n_rel = 0;
        repeat (10) step(1'b1);
        chk("release_once", n_rel, 1);
        chk("long_active_cleared", int'(long_active), 0);
        chk("level_released", int'(btn_level), 0);

        // Bounce every 2 cycles: never accepted
        n_press = 0;
        for (int i = 0; i < 30; i++) step(((i / 2) % 2) == 1 ? 1'b1 : 1'b0);
        repeat (10) step(1'b1);
        chk("bounce_no_press", n_press, 0);
        chk("bounce_level", int'(btn_level), 0);

        // Release glitch while held does not restart the long timer
        repeat (6) step(1'b0);
        n_long = 0; n_rel = 0;
        repeat (10) step(1'b0);
        repeat (2) step(1'b1);
        repeat (25) step(1'b0);
        chk("glitch_no_release", n_rel, 0);
        chk("glitch_long_once", n_long, 1);
        repeat (10) step(1'b1);

        // Random bouncy segments
        for (int s = 0; s < 80; s++) begin
            rpin = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 9);
            repeat (len) step(rpin);
        end
        repeat (10) step(1'b1);

        // 256 clean presses wrap the counter back to its starting value
        c0 = m_cnt;
        n_press = 0;
        repeat (256) begin
            repeat (7) step(1'b0);
            repeat (7) step(1'b1);
        end
        chk("press_total_256", n_press, 256);
        chk("count_wrap", int'(press_count), int'(c0));

        // Reset mid-hold with pin still pressed
        repeat (14) step(1'b0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset_level", int'(btn_level), 0);
        repeat (3) step(1'b0);
        reset_n = 1'b1;
        repeat (5) step(1'b0);
        chk("post_reset_wait", int'(btn_level), 0);
        step(1'b0);
        chk("post_reset_press", int'(press_pulse), 1);
        chk("post_reset_count", int'(press_count), 1);
        repeat (10) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
